// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clk_div_pkg;

    localparam int DEF_HALF_DFLT = 2;
    localparam int MAX_CH        = 8;
    localparam int HALF_W        = 8;

    typedef logic [HALF_W-1:0] half_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: half-period counter, toggle, rise tick, enable and
// shadow application at a period boundary.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = DEF_HALF_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apply_i,
    input  logic [CNT_W-1:0] half_i,
    input  logic             en_i,
    output logic             div_clk_o,
    output logic             tick_o,
    output logic             fall_o,
    output logic             en_o
);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             wrap;

    assign wrap = (cnt_q == h_q - CNT_W'(1));

    always_comb begin
        h_d    = h_q;
        cnt_d  = cnt_q;
        en_d   = en_q;
        div_d  = div_q;
        tick_d = 1'b0;
        if (apply_i) begin
            // A new setting always starts from the low phase with a fresh count.
            h_d   = half_i;
            cnt_d = '0;
            div_d = 1'b0;
            en_d  = en_i;
        end else if (!en_q) begin
            cnt_d = '0;
            div_d = 1'b0;
        end else if (wrap) begin
            cnt_d  = '0;
            div_d  = !div_q;
            tick_d = !div_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= CNT_W'(DEF_HALF);
            cnt_q  <= '0;
            en_q   <= 1'b1;
            div_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            h_q    <= h_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign div_clk_o = div_q;
    assign tick_o    = tick_q;
    assign fall_o    = en_q && div_q && wrap;
    assign en_o      = en_q;

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel clock divider: config handshake with a single shadow slot applied
// at the target channel's period boundary. CLKDIV_GATE_EN enables per-channel gating.
module multi_clk_div
    import clk_div_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = DEF_HALF_DFLT
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cfg_valid,
    output logic                                         cfg_ready,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                             cfg_half,
    input  logic                                         cfg_en,
    output logic [NUM_CH-1:0]                            div_clk,
    output logic [NUM_CH-1:0]                            tick
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // cfg handshake: a write transfers on a clk edge with cfg_valid && cfg_ready;
    // cfg_ready is low exactly while the shadow slot holds an unapplied write.
    logic             pend_q, pend_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_en_q, pend_en_d;
    logic             pend_bad;
    logic [NUM_CH-1:0] apply, fall, ch_en;

    assign cfg_ready = !pend_q;
    assign pend_bad  = (int'(pend_ch_q) >= NUM_CH);

`ifndef CLKDIV_GATE_EN
    logic cfg_en_unused;
    assign cfg_en_unused = cfg_en;
`endif

    always_comb begin
        pend_d      = pend_q;
        pend_ch_d   = pend_ch_q;
        pend_half_d = pend_half_q;
        pend_en_d   = pend_en_q;
        if (pend_q && (pend_bad || (|apply)))
            pend_d = 1'b0;
        if (cfg_valid && cfg_ready) begin
            pend_d      = 1'b1;
            pend_ch_d   = cfg_ch;
            pend_half_d = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
`ifdef CLKDIV_GATE_EN
            pend_en_d   = cfg_en;
`else
            pend_en_d   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_ch_q   <= '0;
            pend_half_q <= '0;
            pend_en_q   <= 1'b1;
        end else begin
            pend_q      <= pend_d;
            pend_ch_q   <= pend_ch_d;
            pend_half_q <= pend_half_d;
            pend_en_q   <= pend_en_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Running channels take the shadow on a falling toggle; idle ones at once.
        assign apply[g] = pend_q && !pend_bad && (pend_ch_q == CH_W'(g)) &&
                          (fall[g] || !ch_en[g]);

        clk_div_ch #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .apply_i   (apply[g]),
            .half_i    (pend_half_q),
            .en_i      (pend_en_q),
            .div_clk_o (div_clk[g]),
            .tick_o    (tick[g]),
            .fall_o    (fall[g]),
            .en_o      (ch_en[g])
        );
    end

endmodule

// File: tb/tb_multi_clk_div.sv
// Bench for multi_clk_div: a phase-based reference model (edges since period start,
// modulo 2H) plus directed and random configuration traffic.
module tb_multi_clk_div;

    localparam int NUM_CH   = 3;
    localparam int CNT_W    = 8;
    localparam int DEF_HALF = 2;
    localparam int CH_W     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic              cfg_en;
    logic [NUM_CH-1:0] div_clk;
    logic [NUM_CH-1:0] tick;

    int checks = 0;
    int errors = 0;

    // reference model state
    int  m_k [NUM_CH];
    int  m_h [NUM_CH];
    bit  m_en[NUM_CH];
    bit  m_pend;
    int  m_pch;
    int  m_ph;
    bit  m_pen;
    logic [NUM_CH-1:0] exp_div;
    logic [NUM_CH-1:0] exp_tick;
    logic              exp_ready;

    multi_clk_div #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_en    (cfg_en),
        .div_clk   (div_clk),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit en_before[NUM_CH];
        bit rdy;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_k[i] = 0; m_h[i] = DEF_HALF; m_en[i] = 1'b1;
            end
            m_pend = 1'b0;
        end else begin
            rdy = !m_pend;
            for (int i = 0; i < NUM_CH; i++) begin
                en_before[i] = m_en[i];
                if (m_en[i]) m_k[i] = (m_k[i] + 1) % (2 * m_h[i]);
            end
            if (m_pend) begin
                if (m_pch >= NUM_CH) begin
                    m_pend = 1'b0;
                end else if (!en_before[m_pch] || m_k[m_pch] == 0) begin
                    m_h[m_pch]  = m_ph;
                    m_k[m_pch]  = 0;
                    m_en[m_pch] = m_pen;
                    m_pend      = 1'b0;
                end
            end
            if (cfg_valid && rdy) begin
                m_pend = 1'b1;
                m_pch  = int'(cfg_ch);
                m_ph   = (cfg_half == '0) ? 1 : int'(cfg_half);
`ifdef CLKDIV_GATE_EN
                m_pen  = cfg_en;
`else
                m_pen  = 1'b1;
`endif
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            exp_div[i]  = m_en[i] && (m_k[i] >= m_h[i]);
            exp_tick[i] = m_en[i] && (m_k[i] == m_h[i]);
        end
        exp_ready = !m_pend;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        bit exp_d0[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
        bit exp_t0[8] = '{0, 1, 0, 0, 0, 1, 0, 0};
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0; cfg_en = 1'b1;
        repeat (12) begin
            cycle();
            checks++;
            if (div_clk !== '0 || tick !== '0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_state div=%b tick=%b ready=%b required div=0 tick=0 ready=1",
                         div_clk, tick, cfg_ready);
            end
        end
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            cycle();
            checks++;
            if (div_clk[0] !== exp_d0[e] || tick[0] !== exp_t0[e]) begin
                errors++;
                $display("FAIL reset_release edge %0d div0=%b tick0=%b required %b %b",
                         e + 1, div_clk[0], tick[0], exp_d0[e], exp_t0[e]);
            end
            checks++;
            if (div_clk !== exp_div || tick !== exp_tick || cfg_ready !== exp_ready) begin
                errors++;
                $display("FAIL reset_model div=%b tick=%b ready=%b required %b %b %b",
                         div_clk, tick, cfg_ready, exp_div, exp_tick, exp_ready);
            end
        end
    endtask

    task automatic test_reprogram();
        int n;
        int ticks[$];
        n = 0;
        while (tick[1] !== 1'b1 && n < 20) begin cycle(); n++; end
        checks++;
        if (tick[1] !== 1'b1) begin
            errors++;
            $display("FAIL reprog_wait tick1=%b required 1 within 20 cycles", tick[1]);
        end
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd5; cfg_en = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0 || div_clk[1] !== 1'b1) begin
            errors++;
            $display("FAIL reprog_accept ready=%b div1=%b required ready=0 div1=1",
                     cfg_ready, div_clk[1]);
        end
        for (int j = 1; j <= 40; j++) begin
            cycle();
            if (j == 1) begin
                checks++;
                if (cfg_ready !== 1'b1 || div_clk[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL reprog_apply ready=%b div1=%b required ready=1 div1=0",
                             cfg_ready, div_clk[1]);
                end
            end
            if (tick[1] === 1'b1) ticks.push_back(j);
            checks++;
            if (div_clk !== exp_div || tick !== exp_tick || cfg_ready !== exp_ready) begin
                errors++;
                $display("FAIL reprog_model div=%b tick=%b ready=%b required %b %b %b",
                         div_clk, tick, cfg_ready, exp_div, exp_tick, exp_ready);
            end
        end
        checks++;
        if (ticks.size() != 4 || ticks[0] != 6 || ticks[1] - ticks[0] != 10 ||
            ticks[3] - ticks[2] != 10) begin
            errors++;
            $display("FAIL reprog_period ticks=%0d first=%0d required 4 ticks first=6 gap=10",
                     ticks.size(), (ticks.size() > 0) ? ticks[0] : -1);
        end
    endtask

    task automatic test_saturation();
        int n;
        logic prev;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd0; cfg_en = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin cycle(); n++; end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_apply ready=%b required 1 within 20 cycles", cfg_ready);
        end
        prev = div_clk[0];
        repeat (8) begin
            cycle();
            checks++;
            if (div_clk[0] === prev) begin
                errors++;
                $display("FAIL sat_toggle div0=%b prev=%b required toggle every cycle",
                         div_clk[0], prev);
            end
            prev = div_clk[0];
            checks++;
            if (div_clk !== exp_div || tick !== exp_tick || cfg_ready !== exp_ready) begin
                errors++;
                $display("FAIL sat_model div=%b tick=%b ready=%b required %b %b %b",
                         div_clk, tick, cfg_ready, exp_div, exp_tick, exp_ready);
            end
        end
    endtask

    task automatic test_gating();
        int n;
`ifdef CLKDIV_GATE_EN
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd2; cfg_en = 1'b0;
        cycle();
        cfg_valid = 1'b0;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin cycle(); n++; end
        repeat (8) begin
            cycle();
            checks++;
            if (div_clk[0] !== 1'b0 || tick[0] !== 1'b0) begin
                errors++;
                $display("FAIL gate_off div0=%b tick0=%b required 0 0", div_clk[0], tick[0]);
            end
            checks++;
            if (div_clk !== exp_div || tick !== exp_tick || cfg_ready !== exp_ready) begin
                errors++;
                $display("FAIL gate_model div=%b tick=%b ready=%b required %b %b %b",
                         div_clk, tick, cfg_ready, exp_div, exp_tick, exp_ready);
            end
        end
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd3; cfg_en = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        n = 0;
        while (tick[0] !== 1'b1 && n < 12) begin cycle(); n++; end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL gate_reenable first rise after %0d cycles required 4", n);
        end
`else
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd3; cfg_en = 1'b0;
        cycle();
        cfg_valid = 1'b0;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin cycle(); n++; end
        n = 0;
        while (tick[0] !== 1'b1 && n < 12) begin cycle(); n++; end
        checks++;
        if (tick[0] !== 1'b1) begin
            errors++;
            $display("FAIL nogate_running tick0=%b required a rise within 12 cycles", tick[0]);
        end
`endif
        n = 0;
        cycle();
        while (tick[0] !== 1'b1 && n < 12) begin cycle(); n++; end
        checks++;
        if (n + 1 != 6) begin
            errors++;
            $display("FAIL gate_period period=%0d required 6", n + 1);
        end
        checks++;
        if (div_clk !== exp_div || tick !== exp_tick || cfg_ready !== exp_ready) begin
            errors++;
            $display("FAIL gate_end_model div=%b tick=%b ready=%b required %b %b %b",
                     div_clk, tick, cfg_ready, exp_div, exp_tick, exp_ready);
        end
    endtask

    task automatic test_boundary();
        int n;
        int low;
        n = 0;
        while (m_k[0] != 2 * m_h[0] - 1 && n < 20) begin cycle(); n++; end
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd4; cfg_en = 1'b1;
        cycle();
        cfg_ch = 2'd2; cfg_half = 8'd7;
        low = 0;
        while (cfg_ready === 1'b0 && low < 20) begin
            low++;
            checks++;
            if (div_clk !== exp_div || tick !== exp_tick || cfg_ready !== exp_ready) begin
                errors++;
                $display("FAIL bound_model div=%b tick=%b ready=%b required %b %b %b",
                         div_clk, tick, cfg_ready, exp_div, exp_tick, exp_ready);
            end
            cycle();
        end
        cfg_valid = 1'b0;
        checks++;
        if (low != 6) begin
            errors++;
            $display("FAIL bound_defer ready low %0d cycles required 6", low);
        end
        repeat (20) begin
            cycle();
            checks++;
            if (div_clk !== exp_div || tick !== exp_tick || cfg_ready !== exp_ready) begin
                errors++;
                $display("FAIL bound_after div=%b tick=%b ready=%b required %b %b %b",
                         div_clk, tick, cfg_ready, exp_div, exp_tick, exp_ready);
            end
        end
    endtask

    task automatic test_invalid_ch();
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd1; cfg_en = 1'b0;
        cycle();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL invalid_accept ready=%b required 0", cfg_ready);
        end
        cycle();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL invalid_return ready=%b required 1", cfg_ready);
        end
        repeat (12) begin
            cycle();
            checks++;
            if (div_clk !== exp_div || tick !== exp_tick || cfg_ready !== exp_ready) begin
                errors++;
                $display("FAIL invalid_model div=%b tick=%b ready=%b required %b %b %b",
                         div_clk, tick, cfg_ready, exp_div, exp_tick, exp_ready);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        n = 0;
        while (tick[1] !== 1'b1 && n < 30) begin cycle(); n++; end
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd7; cfg_en = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pending ready=%b required 0", cfg_ready);
        end
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (cfg_ready !== 1'b1 || div_clk !== '0 || tick !== '0) begin
            errors++;
            $display("FAIL midrst_state ready=%b div=%b tick=%b required 1 0 0",
                     cfg_ready, div_clk, tick);
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (div_clk[1] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_edge1 div1=%b required 0", div_clk[1]);
        end
        cycle();
        checks++;
        if (div_clk[1] !== 1'b1 || tick[1] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_edge2 div1=%b tick1=%b required 1 1", div_clk[1], tick[1]);
        end
        repeat (20) begin
            cycle();
            checks++;
            if (div_clk !== exp_div || tick !== exp_tick || cfg_ready !== exp_ready) begin
                errors++;
                $display("FAIL midrst_model div=%b tick=%b ready=%b required %b %b %b",
                         div_clk, tick, cfg_ready, exp_div, exp_tick, exp_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        repeat (400) begin
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 3));
            cfg_half  = CNT_W'($urandom_range(0, 4));
            cfg_en    = ($urandom_range(0, 3) != 0);
            cycle();
            checks++;
            if (div_clk !== exp_div || tick !== exp_tick || cfg_ready !== exp_ready) begin
                errors++;
                $display("FAIL random_model div=%b tick=%b ready=%b required %b %b %b",
                         div_clk, tick, cfg_ready, exp_div, exp_tick, exp_ready);
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reprogram();
        test_saturation();
        test_gating();
        test_boundary();
        test_invalid_ch();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
